// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: posted one-entry write buffer, blocking
// loads with buffer forwarding, bus timeout with a sticky error flag.
module data_mem_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  output logic         mem_stall,
  output logic         bus_err,
  output logic         bus_req,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [W-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [W-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, LOAD, DONE} state_e;

  state_e         state_q, state_d;
  logic           wb_valid_q, wb_valid_d;
  logic [W-1:0]   wb_addr_q, wb_addr_d;
  logic [W-1:0]   wb_data_q, wb_data_d;
  logic [W-1:0]   l_data_q, l_data_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic ack, tmo, match, wb_free, stall;

  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    l_data_d   = l_data_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;

    ack     = req_q & bus_ack;
    tmo     = req_q & ~bus_ack & (cnt_q == CW'(TIMEOUT - 1));
    match   = wb_valid_q & (l_addr[W-1:2] == wb_addr_q[W-1:2]);
    wb_free = ~wb_valid_q | ((state_q == WRITE) & ack);

    if (req_q & ~bus_ack) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (load_en & ~wb_valid_q) begin
          state_d = LOAD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {l_addr[W-1:2], 2'b00};
          cnt_d   = '0;
        end else if (wb_valid_q) begin
          state_d = WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {wb_addr_q[W-1:2], 2'b00};
          wdata_d = wb_data_q;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (ack) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (tmo) begin
          req_d      = 1'b0;
          err_d      = 1'b1;
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      LOAD: begin
        if (ack) begin
          req_d    = 1'b0;
          l_data_d = bus_rdata;
          state_d  = DONE;
        end else if (tmo) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          l_data_d = '1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // CPU side; a store accepted in the ack cycle refills the buffer
    if (load_en) begin
      if (state_q == DONE) begin
        stall = 1'b0;
      end else if (match) begin
        l_data_d = wb_data_q;
      end else begin
        stall = 1'b1;
      end
    end else if (store_en) begin
      if (wb_free) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = s_addr;
        wb_data_d  = s_data;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      l_data_q   <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      l_data_q   <= l_data_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_stall = ~rst & stall;
  assign l_data    = l_data_q;
  assign bus_err   = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus random load/store
// traffic checked against a word-memory model and a variable-latency bus.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_en, store_en, bus_ack;
  logic [31:0] l_addr, s_addr, s_data, bus_rdata;
  logic [31:0] l_data, bus_addr, bus_wdata;
  logic        mem_stall, bus_err, bus_req, bus_we;

  data_mem_ctrl #(.W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
    .mem_stall(mem_stall), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit [31:0] bmem [bit [31:0]];
  bit [31:0] shadow [bit [31:0]];
  bit [31:0] wlog_a [$];
  bit [31:0] wlog_d [$];

  bit ack_en = 1'b1;
  bit rand_lat = 1'b0;
  int ack_lat = 1;
  int lat = 1;
  int rc = 0;
  int last_len = 0;
  bit prev_req = 1'b0;

  function automatic bit [31:0] init_val(bit [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit [31:0] rd_word(bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_val(a);
  endfunction

  function automatic bit [31:0] exp_word(bit [31:0] a);
    bit [31:0] w;
    w = {a[31:2], 2'b00};
    return shadow.exists(w) ? shadow[w] : init_val(w);
  endfunction

  // Memory-side responder: ack after a per-transaction latency
  always @(negedge clk) begin
    if (bus_req) begin
      if (!prev_req) begin
        rc = 1;
        lat = rand_lat ? int'($urandom_range(1, 3)) : ack_lat;
      end else begin
        rc++;
      end
      bus_ack = ack_en && (rc == lat);
      bus_rdata = rd_word(bus_addr);
      if (bus_ack && bus_we) begin
        bmem[bus_addr] = bus_wdata;
        wlog_a.push_back(bus_addr);
        wlog_d.push_back(bus_wdata);
      end
    end else begin
      if (prev_req) last_len = rc;
      bus_ack = 1'b0;
    end
    prev_req = bus_req;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(bit ld, logic [31:0] a, logic [31:0] d,
                    output int st);
    @(negedge clk);
    load_en = ld;
    store_en = !ld;
    l_addr = a;
    s_addr = a;
    s_data = d;
    st = 0;
    forever begin
      #1;
      if (!mem_stall) break;
      st++;
      if (st >= 100) begin
        n_chk++;
        n_fail++;
        $error("FAIL op_bound: observed stall %0d expected completion", st);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    load_en = 1'b0;
    store_en = 1'b0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, output int st);
    shadow[{a[31:2], 2'b00}] = d;
    op(1'b0, a, d, st);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int st;
    int base;
    rst = 1'b1;
    load_en = 1'b1;
    store_en = 1'b0;
    l_addr = 32'h100;
    s_addr = 0;
    s_data = 0;
    bus_ack = 1'b0;
    bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_ldata", l_data, 0);
    chk("rst_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b0;
    load_en = 1'b0;

    // Blocking load, ack on third request cycle
    bmem[32'h100] = 32'h12345678;
    shadow[32'h100] = 32'h12345678;
    ack_lat = 3;
    op(1'b1, 32'h100, 0, st);
    chk("ld_stall", st, 4);
    chk("ld_data", l_data, 32'h12345678);
    chk("ld_reqlen", last_len, 3);
    chk("ld_wlog", wlog_a.size(), 0);

    // Store then forwarded load
    ack_lat = 1;
    base = wlog_a.size();
    store(32'h200, 32'hAABBCCDD, st);
    chk("st_stall", st, 0);
    op(1'b1, 32'h202, 0, st);
    chk("fwd_stall", st, 0);
    chk("fwd_data", l_data, 32'hAABBCCDD);
    idle(5);
    chk("fwd_wcnt", wlog_a.size(), base + 1);
    chk("fwd_waddr", wlog_a[base], 32'h200);
    chk("fwd_wdata", wlog_d[base], 32'hAABBCCDD);

    // Back-to-back stores, ack on second cycle
    ack_lat = 2;
    base = wlog_a.size();
    store(32'h240, 32'h1111_AAAA, st);
    chk("b2b_st1", st, 0);
    store(32'h244, 32'h2222_BBBB, st);
    chk("b2b_st2", st, 2);
    idle(8);
    chk("b2b_wcnt", wlog_a.size(), base + 2);
    chk("b2b_a0", wlog_a[base], 32'h240);
    chk("b2b_a1", wlog_a[base+1], 32'h244);
    chk("b2b_d1", wlog_d[base+1], 32'h2222_BBBB);

    // Load behind a non-matching buffered store
    ack_lat = 1;
    store(32'h300, 32'h3030_3030, st);
    op(1'b1, 32'h400, 0, st);
    chk("drain_stall", st, 4);
    chk("drain_data", l_data, exp_word(32'h400));
    chk("drain_mem", rd_word(32'h300), 32'h3030_3030);

    // Load timeout
    idle(2);
    ack_en = 1'b0;
    op(1'b1, 32'h500, 0, st);
    chk("tmo_stall", st, 5);
    chk("tmo_len", last_len, 4);
    chk("tmo_data", l_data, 32'hFFFFFFFF);
    chk("tmo_err", bus_err, 1);
    ack_en = 1'b1;
    idle(2);
    op(1'b1, 32'h104, 0, st);
    chk("post_tmo_data", l_data, exp_word(32'h104));
    chk("post_tmo_err", bus_err, 1);

    // Reset during a load
    ack_en = 1'b0;
    @(negedge clk);
    load_en = 1'b1;
    l_addr = 32'h600;
    @(negedge clk);
    #1;
    chk("rl_req_up", bus_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rl_req", bus_req, 0);
    chk("rl_ldata", l_data, 0);
    chk("rl_err", bus_err, 0);
    chk("rl_addr", bus_addr, 0);
    chk("rl_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    load_en = 1'b0;
    ack_en = 1'b1;
    idle(2);
    chk("rl_idle_req", bus_req, 0);

    // Random traffic against the word-memory model
    rand_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bit ld;
      bit [31:0] a, d;
      ld = 1'($urandom_range(0, 1));
      a = 32'h700 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      d = $urandom;
      if (ld) begin
        op(1'b1, a, 0, st);
        chk("rnd_load", l_data, exp_word(a));
      end else begin
        store(a, d, st);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(10);
    for (int w = 0; w < 8; w++)
      chk("rnd_mem", rd_word(32'h700 + 32'(4 * w)), exp_word(32'h700 + 32'(4 * w)));
    chk("rnd_err", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
